// File: rtl/pattern_scan_ctrl.sv
// Serial pattern scanner: shifts a captured word out MSB first and counts
// (overlapping) hits of a 4-bit pattern over a sliding window.
//
// state | meaning
// IDLE  | waiting for start; match_count holds the last job's result
// SHIFT | one data bit per cycle on bit_out, window/match update per edge
// DONE  | one-cycle completion pulse, then back to IDLE
module pattern_scan_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] data_in,
  input  logic [3:0]       pattern,
  output logic             busy,
  output logic             done,
  output logic             bit_out,
  output logic             bit_valid,
  output logic [5:0]       match_count
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [3:0]       pat;
  logic [3:0]       window;
  logic [2:0]       fill;
  logic [CW-1:0]    bitcnt;

  logic       cur_bit;
  logic [3:0] win_next;
  logic       hit;

  assign cur_bit   = shreg[WIDTH-1];
  assign win_next  = {window[2:0], cur_bit};
  // fill counts bits already in the window, so 3 means win_next is complete
  assign hit       = (fill >= 3'd3) && (win_next == pat);
  assign bit_valid = busy;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      shreg       <= '0;
      pat         <= '0;
      window      <= '0;
      fill        <= '0;
      bitcnt      <= '0;
      match_count <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bit_out     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shreg       <= data_in;
            pat         <= pattern;
            window      <= '0;
            fill        <= '0;
            bitcnt      <= '0;
            match_count <= '0;
            busy        <= 1'b1;
            bit_out     <= data_in[WIDTH-1];
            state       <= SHIFT;
          end
        end

        SHIFT: begin
          if (abort) begin
            match_count <= '0;
            busy        <= 1'b0;
            bit_out     <= 1'b0;
            state       <= IDLE;
          end else begin
            shreg  <= {shreg[WIDTH-2:0], 1'b0};
            window <= win_next;
            bitcnt <= bitcnt + 1'b1;
            if (fill != 3'd4)
              fill <= fill + 3'd1;
            if (hit && (match_count != 6'd63))
              match_count <= match_count + 6'd1;
            if (bitcnt == LAST_BIT) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              bit_out <= 1'b0;
              state   <= DONE;
            end else begin
              bit_out <= shreg[WIDTH-2];
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          bit_out <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl: scoreboard of expected serial bits and
// per-job match counts, checked every cycle with immediate assertions.
module tb_pattern_scan_ctrl;
  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [3:0]   pattern = '0;
  logic         busy, done, bit_out, bit_valid;
  logic [5:0]   match_count;

  pattern_scan_ctrl #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .data_in(data_in), .pattern(pattern), .busy(busy), .done(done),
    .bit_out(bit_out), .bit_valid(bit_valid), .match_count(match_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int last_mc = 0;
  bit done_due = 1'b0;
  bit bitq[$];
  int cntq[$];

  function automatic int model_count(logic [W-1:0] d, logic [3:0] p);
    int n = 0;
    for (int i = 3; i < W; i++)
      if ({d[W+2-i], d[W+1-i], d[W-i], d[W-1-i]} == p) n++;
    if (n > 63) n = 63;
    return n;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit exp_busy, exp_done, b;
    int c;
    @(posedge clock);
    #1;
    exp_busy = (bitq.size() > 0);
    exp_done = done_due;
    done_due = 1'b0;
    chk("busy", busy, exp_busy);
    chk("bit_valid", bit_valid, exp_busy);
    chk("done", done, exp_done);
    if (done) done_seen++;
    if (exp_busy) begin
      b = bitq.pop_front();
      chk("bit_out", bit_out, b);
      if (bitq.size() == 0) done_due = 1'b1;
    end else begin
      chk("bit_out_idle", bit_out, 0);
    end
    if (exp_done) begin
      c = cntq.pop_front();
      chk("match_count_done", match_count, c);
      last_mc = c;
    end else if (!exp_busy) begin
      chk("match_count_hold", match_count, last_mc);
    end
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  // Drives a job request for one edge; start stays high when keep is set.
  task automatic issue(logic [W-1:0] d, logic [3:0] p, int exp, bit keep);
    data_in = d;
    pattern = p;
    start   = 1'b1;
    for (int j = 0; j < W; j++) bitq.push_back(d[W-1-j]);
    cntq.push_back(exp);
    tick();
    if (!keep) start = 1'b0;
    data_in = ~d;
    pattern = ~p;
  endtask

  task automatic flush();
    bitq.delete();
    cntq.delete();
    done_due = 1'b0;
    last_mc  = 0;
  endtask

  initial begin
    int ds0;
    logic [W-1:0] rd;
    logic [3:0]   rp;

    reset = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    run(3);
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b1;
    run(2);

    issue(16'h9249, 4'b1001, 5, 1'b0);
    run(18);
    issue(16'h0000, 4'b0000, 13, 1'b0);
    run(18);
    issue(16'hFFFF, 4'b1001, 0, 1'b0);
    run(18);

    for (int k = 0; k < 4; k++) begin
      rd = W'($urandom);
      rp = 4'($urandom_range(0, 15));
      issue(rd, rp, model_count(rd, rp), 1'b0);
      run(17 + k);
    end

    // start held high: accepted only every 18 cycles
    ds0 = done_seen;
    for (int k = 0; k < 3; k++) begin
      issue(16'h9249, 4'b1001, 5, 1'b1);
      data_in = 16'h9249;
      pattern = 4'b1001;
      run(17);
    end
    start = 1'b0;
    run(2);
    chk("held_start_jobs", done_seen - ds0, 3);

    // abort ignored in IDLE and in DONE
    abort = 1'b1;
    issue(16'h9249, 4'b1001, 5, 1'b0);
    abort = 1'b0;
    run(15);
    ds0 = done_seen;
    tick();
    chk("done_before_abort", done_seen - ds0, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    run(2);

    // abort in the 5th SHIFT cycle
    issue(16'h9249, 4'b1001, 5, 1'b0);
    run(4);
    abort = 1'b1;
    flush();
    ds0 = done_seen;
    tick();
    abort = 1'b0;
    run(20);
    chk("abort5_no_done", done_seen - ds0, 0);

    // abort in the final SHIFT cycle beats the transition to DONE
    issue(16'h0000, 4'b0000, 13, 1'b0);
    run(15);
    abort = 1'b1;
    flush();
    ds0 = done_seen;
    tick();
    abort = 1'b0;
    run(5);
    chk("abort16_no_done", done_seen - ds0, 0);

    // reset in the 8th SHIFT cycle, then restart on the first released edge
    issue(16'h9249, 4'b1001, 5, 1'b0);
    run(7);
    reset = 1'b0;
    flush();
    ds0 = done_seen;
    tick();
    chk("reset_mc", match_count, 0);
    reset = 1'b1;
    issue(16'h9249, 4'b1001, 5, 1'b0);
    run(18);
    chk("reset_restart_done", done_seen - ds0, 1);
    chk("queues_drained", bitq.size() + cntq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, number of data bits scanned per job; legal range 4..32.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset; sampled only on the rising clock edge.
REQ-004 SHALL have port start  input  1  job request; sampled only in IDLE.
REQ-005 SHALL have port abort  input  1  cancels a job in SHIFT.
REQ-006 SHALL have port data_in  input  WIDTH  word to scan, MSB first; captured on accepted start.
REQ-007 SHALL have port pattern  input  4  target pattern, pattern[3] oldest bit; captured on accepted start.
REQ-008 SHALL have port busy  output  1  high in SHIFT.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port bit_out  output  1  serial bit currently scanned.
REQ-011 SHALL have port bit_valid  output  1  qualifies bit_out; equals busy.
REQ-012 SHALL have port match_count  output  6  number of pattern hits in the last job.

Function
REQ-013 SHALL implement Moore states IDLE, SHIFT, DONE; outputs decoded from registered state and datapath registers only.
REQ-014 IDLE: start=1 SHALL capture data_in into the shift register and pattern into the pattern register, clear match_count, fill counter and bit counter to 0, and go to SHIFT.
REQ-015 start SHALL be ignored in SHIFT and DONE; no queuing.
REQ-016 SHIFT: each cycle bit_out SHALL equal shift register MSB; on the edge, shift register shifts left by 1 (zero fill), bit counter increments.
REQ-017 SHALL keep a 4-bit window; each SHIFT edge window <= {window[2:0], bit_out}; fill counter saturates at 4.
REQ-018 A hit SHALL occur on a SHIFT edge when fill counter (before update) >= 3 and {window[2:0], bit_out} == pattern; match_count increments on that same edge.
REQ-019 Overlapping hits SHALL all be counted (window is never cleared after a hit).
REQ-020 match_count SHALL saturate at 63, never wrap.
REQ-021 SHIFT SHALL last exactly WIDTH cycles; on the edge that consumes bit WIDTH-1, go to DONE.
REQ-022 DONE: done=1, busy=0 for exactly one cycle; next state IDLE unconditionally.
REQ-023 match_count SHALL hold its final value from DONE until the next accepted start.
REQ-024 Latency: start sampled at edge k -> busy high cycles k+1..k+WIDTH, done high in cycle k+WIDTH+1; next start accepted at earliest edge k+WIDTH+2.
REQ-025 abort=1 in SHIFT SHALL go to IDLE on that edge, clear match_count to 0, no done pulse; abort takes priority over the final-bit transition to DONE.
REQ-026 abort SHALL be ignored in IDLE and DONE.
REQ-027 bit_out SHALL be 0 whenever bit_valid=0.

Reset
REQ-028 reset=0 at a rising edge SHALL force IDLE and clear shift register, pattern register, window, all counters, busy, done, bit_out, bit_valid, match_count to 0, overriding start and abort.
REQ-029 reset asserted mid-SHIFT SHALL abandon the job with no done pulse; first start is accepted at the first edge with reset=1.

Verification
REQ-030 data_in=16'h9249, pattern=4'b1001, start one cycle -> busy 16 cycles, bit_out sequence 1001001001001001, done 17 cycles after start edge, match_count=5.
REQ-031 data_in=16'h0000, pattern=4'b0000 -> match_count=13; data_in=16'hFFFF, pattern=4'b1001 -> match_count=0.
REQ-032 start held high continuously with data_in=16'h9249, pattern=4'b1001 -> start during SHIFT/DONE ignored; jobs back-to-back every 18 cycles, each match_count=5.
REQ-033 abort=1 in 5th SHIFT cycle -> busy=0 next cycle, done never pulses, match_count=0.
REQ-034 abort=1 on final (16th) SHIFT cycle -> IDLE, no done, match_count=0.
REQ-035 reset=0 in 8th SHIFT cycle -> next cycle all outputs 0; new start with data_in=16'h9249 yields match_count=5.
